// File: rtl/tcp_tx_header_builder.sv
// ---------------------------------------------------------------------------
// tcp_tx_header_builder
//
// Purpose:
//   Takes one TCP segment request (flags, ports, sequence/ack numbers,
//   window) per handshake. Optionally computes the 16-bit one's-complement
//   TCP checksum over the header words plus a caller-supplied pseudo-header
//   partial sum. Then serializes the 20-byte option-less header MSB-first
//   onto a valid/ready byte stream.
//
// Parameters:
//   CSUM_EN    1 = compute the checksum (10-cycle CSUM phase).
//              0 = send the checksum field as 0x0000 and skip CSUM.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   hdr_vld / hdr_rdy    request handshake (hdr_rdy high only while idle)
//   syn/ack/fin/rst/psh  flag bits of the requested segment
//   src_port, dst_port   local / remote port
//   seq_number           sequence number
//   ack_number           acknowledgement number
//   window               advertised window
//   pseudo_sum           folded one's-complement sum of the IP pseudo-header
//   tx_data / tx_vld     header byte stream (registered)
//   tx_rdy               consumer accepts the presented byte
//   tx_last              marks the final header byte (byte 19)
// ---------------------------------------------------------------------------
module tcp_tx_header_builder #(
  parameter int CSUM_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hdr_vld,
  output logic        hdr_rdy,
  input  logic        syn_flag,
  input  logic        ack_flag,
  input  logic        fin_flag,
  input  logic        rst_flag,
  input  logic        psh_flag,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic [31:0] seq_number,
  input  logic [31:0] ack_number,
  input  logic [15:0] window,
  input  logic [15:0] pseudo_sum,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic        tx_last
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CSUM = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  logic [1:0]  state;
  logic [3:0]  idx;
  logic [4:0]  bidx;
  logic [15:0] acc;
  logic [15:0] csum;

  logic [15:0] src_q;
  logic [15:0] dst_q;
  logic [31:0] seq_q;
  logic [31:0] ack_q;
  logic [15:0] win_q;
  // Flag bits in header order: {ack, psh, rst, syn, fin}
  logic [4:0]  flags_q;

  logic [16:0] sum17;
  logic [15:0] acc_next;

  // Header word i (0..9) built from the captured request. Word 8 is the
  // checksum register, which is held at zero while the sum is being
  // accumulated, so the CSUM phase naturally treats w8 as zero.
  function automatic logic [15:0] word_at(input logic [3:0] i);
    case (i)
      4'd0:    word_at = src_q;
      4'd1:    word_at = dst_q;
      4'd2:    word_at = seq_q[31:16];
      4'd3:    word_at = seq_q[15:0];
      4'd4:    word_at = ack_q[31:16];
      4'd5:    word_at = ack_q[15:0];
      4'd6:    word_at = {4'h5, 4'h0, 2'b00, 1'b0, flags_q};
      4'd7:    word_at = win_q;
      4'd8:    word_at = csum;
      default: word_at = 16'h0000;
    endcase
  endfunction

  // Even byte indices carry the high half of a word, odd ones the low half.
  function automatic logic [7:0] byte_at(input logic [4:0] b);
    logic [15:0] w;
    w = word_at(b[4:1]);
    byte_at = b[0] ? w[7:0] : w[15:8];
  endfunction

  assign hdr_rdy = (state == IDLE);

  // One checksum step: add the current word and fold the carry back in.
  // Both operands are at most 0xFFFF, so the folded result never overflows
  // a second time.
  always_comb begin
    sum17    = {1'b0, acc} + {1'b0, word_at(idx)};
    acc_next = sum17[15:0] + {15'd0, sum17[16]};
  end

  // Main control: capture on handshake, accumulate one word per cycle,
  // then stream bytes under valid/ready. The first byte is loaded on the
  // transition into SEND so tx_vld rises exactly when the state does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 4'd0;
      bidx    <= 5'd0;
      acc     <= 16'h0000;
      csum    <= 16'h0000;
      src_q   <= 16'h0000;
      dst_q   <= 16'h0000;
      seq_q   <= 32'h0000_0000;
      ack_q   <= 32'h0000_0000;
      win_q   <= 16'h0000;
      flags_q <= 5'd0;
      tx_vld  <= 1'b0;
      tx_last <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (hdr_vld) begin
            src_q   <= src_port;
            dst_q   <= dst_port;
            seq_q   <= seq_number;
            ack_q   <= ack_number;
            win_q   <= window;
            flags_q <= {ack_flag, psh_flag, rst_flag, syn_flag, fin_flag};
            acc     <= pseudo_sum;
            idx     <= 4'd0;
            bidx    <= 5'd0;
            csum    <= 16'h0000;
            if (CSUM_EN != 0) begin
              state <= CSUM;
            end else begin
              // Byte 0 comes straight from the input since the capture
              // registers are only being loaded on this same edge.
              state   <= SEND;
              tx_vld  <= 1'b1;
              tx_last <= 1'b0;
              tx_data <= src_port[15:8];
            end
          end
        end

        CSUM: begin
          acc <= acc_next;
          idx <= idx + 4'd1;
          if (idx == 4'd9) begin
            csum    <= ~acc_next;
            state   <= SEND;
            tx_vld  <= 1'b1;
            tx_last <= 1'b0;
            tx_data <= src_q[15:8];
          end
        end

        SEND: begin
          // tx_vld is always high here, so tx_rdy alone means acceptance.
          if (tx_rdy) begin
            if (bidx == 5'd19) begin
              state   <= IDLE;
              bidx    <= 5'd0;
              tx_vld  <= 1'b0;
              tx_last <= 1'b0;
              tx_data <= 8'h00;
            end else begin
              bidx    <= bidx + 5'd1;
              tx_data <= byte_at(bidx + 5'd1);
              tx_last <= (bidx == 5'd18);
            end
          end
        end

        default: begin
          state   <= IDLE;
          tx_vld  <= 1'b0;
          tx_last <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tcp_tx_header_builder.md
Name: tcp_tx_header_builder

Overview:
- Downstream stage of the TCP server connection controller.
- Accepts one segment request per handshake: flag bits (SYN/ACK/FIN/RST/PSH), ports, sequence/ack numbers, window.
- Computes the 16-bit one's-complement TCP checksum over the header plus a caller-supplied pseudo-header partial sum.
- Serializes the 20-byte header (no options) MSB-first onto a valid/ready byte stream feeding the TX engine.

Parameters:
- CSUM_EN, 1, 1 = compute checksum; 0 = checksum field sent as 0x0000 and the CSUM state is skipped.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- hdr_vld  in  1  segment request valid.
- hdr_rdy  out  1  builder idle, request accepted when hdr_vld&&hdr_rdy.
- syn_flag  in  1  SYN bit.
- ack_flag  in  1  ACK bit.
- fin_flag  in  1  FIN bit.
- rst_flag  in  1  RST bit.
- psh_flag  in  1  PSH bit.
- src_port  in  16  local port.
- dst_port  in  16  remote port.
- seq_number  in  32  sequence number.
- ack_number  in  32  acknowledgement number.
- window  in  16  advertised window.
- pseudo_sum  in  16  folded one's-complement sum of the IP pseudo-header.
- tx_data  out  8  header byte.
- tx_vld  out  1  tx_data valid.
- tx_rdy  in  1  consumer accepts byte.
- tx_last  out  1  marks byte 19.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, tx_vld=0, tx_last=0, tx_data=0x00, byte index=0, accumulator=0. hdr_rdy=1 from the first cycle after reset. Reset mid-CSUM or mid-SEND aborts immediately; no partial header resumes.
- hdr_rdy = (state==IDLE), combinational from state.
- All request inputs are captured into registers at handshake and may change afterwards.
- Header word layout (w0..w9):
  - w0 = src_port, w1 = dst_port.
  - w2/w3 = seq_number[31:16]/[15:0].
  - w4/w5 = ack_number[31:16]/[15:0].
  - w6 = {4'h5, 4'h0, 2'b00, 1'b0 URG, ack, psh, rst, syn, fin}.
  - w7 = window, w8 = checksum, w9 = 16'h0000 urgent pointer.
- Bytes are sent in order w0[15:8], w0[7:0], … w9[7:0]; 20 bytes total.
- States:
  - IDLE: on handshake, capture fields and set acc=pseudo_sum, idx=0. Next state is CSUM if CSUM_EN=1, else SEND with checksum=0x0000.
  - CSUM: one word per cycle. sum17 = acc + w[idx] (w8 treated as 0); acc = sum17[15:0] + sum17[16] (end-around carry, never re-overflows). After idx=9 is added (10 cycles), checksum=~acc and the next state is SEND.
  - SEND:
    - tx_vld=1 and tx_data=byte[bidx], registered.
    - On tx_vld&&tx_rdy, bidx increments and the next byte is presented the following cycle.
    - tx_vld stays high with tx_data stable while tx_rdy=0.
    - tx_last=1 exactly when bidx=19.
    - When byte 19 is accepted: next state IDLE, tx_vld=0, tx_last=0.
- Latency:
  - Handshake at cycle T → first byte valid at T+11 (CSUM_EN=1) or T+1 (CSUM_EN=0).
  - With tx_rdy held high, the header completes in 20 consecutive cycles.
- Back-to-back: hdr_rdy rises the cycle after byte 19 is accepted; a new request is accepted then. No request is accepted while busy.
- A checksum result of 0x0000 is sent as-is (no 0xFFFF substitution).

Test Plan:
- SYN-ACK, CSUM_EN=1: src 0x1F90, dst 0xC350, seq 0x00000001, ack 0, syn=ack=1, window 0x0400, pseudo_sum 0, tx_rdy=1 → bytes 1F 90 C3 50 00 00 00 01 00 00 00 00 50 12 04 00 C9 0B 00 00. First tx_vld at T+11; tx_last on byte 20 only; hdr_rdy low for 30 cycles.
- Carry fold: same request with pseudo_sum=0xFFFF → checksum bytes C9 0B (adding 0xFFFF in one's complement leaves the sum unchanged). All other bytes identical.
- Backpressure: toggle tx_rdy 1-0-0-1 pseudo-randomly → byte sequence identical to the first test. tx_data/tx_vld are stable during stalls; no byte is duplicated or dropped.
- Reset mid-SEND: assert rst after 7 bytes accepted → next cycle tx_vld=0, hdr_rdy=1. A fresh FIN+ACK request (flags byte 0x11) then streams a complete 20-byte header with a correct checksum.
- CSUM_EN=0: RST request (flags 0x04) → first byte at T+1, bytes 16–17 = 00 00.
- Back-to-back: hdr_vld held high with two different requests → second accepted the cycle after the first's byte 19 handshake. The second header is correct and is not corrupted by the first request's inputs.
